// File: rtl/picorv32_mem_arbiter_if.sv
`timescale 1ns/1ps
// picorv32_mem_arbiter_if
//   One picorv32-native memory port: valid/ready handshake, request fields and
//   the response (read data plus an error flag raised on watchdog completion).
//   master : side that issues requests (drives valid/instr/addr/wdata/wstrb)
//   slave  : side that answers them (drives ready/rdata/err)
//   The downstream memory has no error signal, so the master modport leaves
//   err out; only requester-facing ports carry it.
interface picorv32_mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata, err
    );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
`timescale 1ns/1ps
// picorv32_mem_arbiter
//   Shares one picorv32-native memory port between two requesters (m0, m1).
//   One transfer in flight; the winner's request fields are latched at grant
//   and held on s until the slave answers or the watchdog expires.
// Ports
//   clk      : clock, all state on the rising edge
//   resetn   : asynchronous active-low reset
//   m0, m1   : requester ports (slave modport: requests in, ready/rdata/err out)
//   s        : downstream memory port (master modport)
//   grant    : one-hot owner of the current transfer, 0 when idle
//   timeout  : one-cycle pulse when the watchdog ends a transfer
// Parameters
//   FIXED_PRIO : 1 = m0 wins every tie, 0 = round-robin on ties
//   TIMEOUT    : busy cycles without s.ready before an error completion, 0 = off
//   ERR_RDATA  : read data returned with an error completion
module picorv32_mem_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    picorv32_mem_arbiter_if.slave  m0,
    picorv32_mem_arbiter_if.slave  m1,
    picorv32_mem_arbiter_if.master s,
    output logic [1:0]             grant,
    output logic                   timeout
);
    localparam int WDOG_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg;
    logic [1:0]        grant_reg;
    logic              last_m1_reg;
    logic              s_valid_reg;
    logic              instr_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [WDOG_W-1:0] wdog_reg;

    // Requesters gathered into arrays so selection and responses index by owner.
    logic [1:0]  req;
    logic [1:0]  req_instr;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];

    assign req          = {m1.valid, m0.valid};
    assign req_instr    = {m1.instr, m0.instr};
    assign req_addr[0]  = m0.addr;
    assign req_addr[1]  = m1.addr;
    assign req_wdata[0] = m0.wdata;
    assign req_wdata[1] = m1.wdata;
    assign req_wstrb[0] = m0.wstrb;
    assign req_wstrb[1] = m1.wstrb;

    logic busy;
    logic complete;
    logic wdog_expire;
    logic finish;
    logic pick_m1;

    assign busy     = (state_reg == BUSY);
    assign complete = busy && s.ready;
    // A ready on the expiry cycle is a normal completion, so expiry needs !s.ready.
    assign wdog_expire = (TIMEOUT != 0) && busy && !s.ready && (wdog_reg == WDOG_LAST);
    assign finish      = complete || wdog_expire;
    // m1 wins when alone, or on a tie in round-robin mode when m0 was served last.
    assign pick_m1 = req[1] && (!req[0] || (!FIXED_PRIO && !last_m1_reg));

    // Responses are combinational off s.ready so the requester sees completion
    // in the same cycle the slave answers.
    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_ready[gi] = grant_reg[gi] && finish;
            assign rsp_err[gi]   = grant_reg[gi] && wdog_expire;
            assign rsp_rdata[gi] = !grant_reg[gi] ? 32'h0 :
                                   complete       ? s.rdata :
                                   wdog_expire    ? ERR_RDATA : 32'h0;
        end
    endgenerate

    assign m0.ready = rsp_ready[0];
    assign m0.rdata = rsp_rdata[0];
    assign m0.err   = rsp_err[0];
    assign m1.ready = rsp_ready[1];
    assign m1.rdata = rsp_rdata[1];
    assign m1.err   = rsp_err[1];

    assign s.valid = s_valid_reg;
    assign s.instr = instr_reg;
    assign s.addr  = addr_reg;
    assign s.wdata = wdata_reg;
    assign s.wstrb = wstrb_reg;
    assign grant   = grant_reg;
    assign timeout = wdog_expire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            grant_reg   <= 2'b00;
            last_m1_reg <= 1'b1;     // m0 takes the first tie after reset
            s_valid_reg <= 1'b0;
            instr_reg   <= 1'b0;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            wstrb_reg   <= 4'h0;
            wdog_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg   <= BUSY;
                        s_valid_reg <= 1'b1;
                        grant_reg   <= pick_m1 ? 2'b10 : 2'b01;
                        last_m1_reg <= pick_m1;
                        instr_reg   <= req_instr[pick_m1];
                        addr_reg    <= req_addr[pick_m1];
                        wdata_reg   <= req_wdata[pick_m1];
                        wstrb_reg   <= req_wstrb[pick_m1];
                        wdog_reg    <= '0;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state_reg   <= IDLE;
                        s_valid_reg <= 1'b0;
                        grant_reg   <= 2'b00;
                        wdog_reg    <= '0;
                    end else if (wdog_reg != '1) begin
                        // Saturates instead of wrapping when the watchdog is off.
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
